// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: funct codes, ALU op class, FSM states.
// Latency: none (constants and a pure decode helper only).
// Backpressure: n/a.
package mdu_pkg;

  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // True for every funct this unit owns; anything else stays with the ALU decoder.
  function automatic logic is_mdu_funct(input logic [5:0] f);
    case (f)
      F_MFHI, F_MTHI, F_MFLO, F_MTLO,
      F_MULT, F_MULTU, F_DIV, F_DIVU: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of shift-add multiply or restoring divide on {acc, opnd}.
// Latency: purely combinational; instances are chained to retire several bits per cycle.
// Backpressure: none, the caller decides when to register the result.
module mdu_step #(
  parameter int DATA_W = 32
) (
  input  logic              div_mode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] opnd,
  input  logic [DATA_W-1:0] oth,
  output logic [DATA_W-1:0] acc_nxt,
  output logic [DATA_W-1:0] opnd_nxt
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // Multiply: acc:opnd is the partial product with the multiplier draining out of opnd's LSB.
  // Divide: acc is the partial remainder, opnd feeds dividend bits in at the MSB and
  // collects quotient bits at the LSB; oth is the divisor.
  always_comb begin
    acc_nxt  = acc;
    opnd_nxt = opnd;
    sum      = {1'b0, acc} + (opnd[0] ? {1'b0, oth} : '0);
    shifted  = {acc, opnd[DATA_W-1]};
    diff     = shifted - {1'b0, oth};
    if (div_mode) begin
      // Partial remainder is always below the divisor, so shifted fits in DATA_W+1 bits
      // and diff's top bit is a clean borrow flag.
      if (!diff[DATA_W]) begin
        acc_nxt  = diff[DATA_W-1:0];
        opnd_nxt = {opnd[DATA_W-2:0], 1'b1};
      end else begin
        acc_nxt  = shifted[DATA_W-1:0];
        opnd_nxt = {opnd[DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_nxt  = sum[DATA_W:1];
      opnd_nxt = {sum[0], opnd[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV unit with HI/LO registers, funct decode and core stall.
// Latency: MULT*/DIV* keep busy_o high for DATA_W/BITS_PER_CYC+1 cycles; MT*/MF* take effect at accept.
// Backpressure: stall_o holds decode on any MDU op while busy_o; ops are in-order and non-cancellable.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int BITS_PER_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              stall_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] result_o
);

  localparam int N     = DATA_W / BITS_PER_CYC;
  localparam int CNT_W = $clog2(N + 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   hi, lo;
  logic [DATA_W-1:0]   acc, opnd, oth;
  logic                div_op, neg_q, neg_r, div_zero;

  logic                is_mdu, accept;
  logic                is_iter, is_signed, is_div;
  logic                sign_a, sign_b;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   q_fix, r_fix;

  logic [DATA_W-1:0]   acc_c  [0:BITS_PER_CYC];
  logic [DATA_W-1:0]   opnd_c [0:BITS_PER_CYC];

  assign is_mdu = valid_i & (alu_op == ALU_OP_RTYPE) & is_mdu_funct(funct);
  assign busy_o = (state != IDLE);
  assign accept = is_mdu & ~busy_o;

  // Classify the op: iterative or not, signed or not, multiply or divide.
  always_comb begin
    is_iter   = 1'b0;
    is_signed = 1'b0;
    is_div    = 1'b0;
    case (funct)
      F_MULT:  begin is_iter = 1'b1; is_signed = 1'b1; end
      F_MULTU: begin is_iter = 1'b1; end
      F_DIV:   begin is_iter = 1'b1; is_signed = 1'b1; is_div = 1'b1; end
      F_DIVU:  begin is_iter = 1'b1; is_div = 1'b1; end
      default: ;
    endcase
  end

  // Work on unsigned magnitudes; MIN stays MIN, which is its correct unsigned magnitude.
  assign sign_a = is_signed & rs_data[DATA_W-1];
  assign sign_b = is_signed & rt_data[DATA_W-1];
  assign mag_a  = sign_a ? -rs_data : rs_data;
  assign mag_b  = sign_b ? -rt_data : rt_data;

  // Chain of single-bit iterations evaluated in one cycle.
  assign acc_c[0]  = acc;
  assign opnd_c[0] = opnd;
  for (genvar i = 0; i < BITS_PER_CYC; i++) begin : g_step
    mdu_step #(.DATA_W(DATA_W)) u_step (
      .div_mode (div_op),
      .acc      (acc_c[i]),
      .opnd     (opnd_c[i]),
      .oth      (oth),
      .acc_nxt  (acc_c[i+1]),
      .opnd_nxt (opnd_c[i+1])
    );
  end

  // Sign fix-up applied on the FIX cycle.
  assign prod_fix = neg_q ? -{acc, opnd} : {acc, opnd};
  assign q_fix    = neg_q ? -opnd : opnd;
  assign r_fix    = neg_r ? -acc : acc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus the combinational stall/result outputs.
  always_comb begin
    state_nxt = state;
    stall_o   = is_mdu & busy_o;
    result_o  = '0;
    if (accept && funct == F_MFHI) result_o = hi;
    if (accept && funct == F_MFLO) result_o = lo;
    case (state)
      IDLE:    if (accept && is_iter) state_nxt = CALC;
      CALC:    if (cnt == CNT_W'(1))  state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch at accept, iteration in CALC, HI/LO writeback at the end of FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      opnd     <= '0;
      oth      <= '0;
      div_op   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (funct == F_MTHI) hi <= rs_data;
            if (funct == F_MTLO) lo <= rs_data;
            if (is_iter) begin
              cnt      <= CNT_W'(N);
              acc      <= '0;
              opnd     <= is_div ? mag_a : mag_b;
              oth      <= is_div ? mag_b : mag_a;
              div_op   <= is_div;
              neg_q    <= sign_a ^ sign_b;
              neg_r    <= sign_a;
              div_zero <= is_div & (rt_data == '0);
            end
          end
        end
        CALC: begin
          acc  <= acc_c[BITS_PER_CYC];
          opnd <= opnd_c[BITS_PER_CYC];
          cnt  <= cnt - CNT_W'(1);
        end
        FIX: begin
          if (div_op) begin
            // On divide-by-zero the remainder path already holds |rs| and neg_r restores
            // its sign, so HI comes back as rs; only LO needs forcing.
            lo <= div_zero ? '1 : q_fix;
            hi <= r_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
